// File: rtl/management_pkg.sv
// Purpose: shared types, key codes and credential table for the keypad login controller.
// Latency: n/a (package only).
// Backpressure: n/a; the keypad stream cannot be stalled.
package management_pkg;

    // Login dialogue states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GET_ID    = 3'd1,
        ST_GET_PWD   = 3'd2,
        ST_LOGGED_IN = 3'd3,
        ST_LOCKED    = 3'd4
    } state_e;

    // Command key codes. 4'hE (reserved) and 4'hF (no key) fall through as "ignored".
    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_LOGIN  = 4'hB;
    localparam logic [3:0] KEY_LOGOUT = 4'hC;
    localparam logic [3:0] KEY_ENTER  = 4'hD;

    // Entry buffer holds at most four BCD digits
    localparam logic [2:0] ENTRY_DIGITS = 3'd4;

    // Credential table: BCD user ID and password pairs
    typedef struct packed {
        logic [15:0] id;
        logic [15:0] pwd;
    } cred_t;

    localparam int CRED_ENTRIES = 4;

    localparam cred_t CRED_TABLE [CRED_ENTRIES] = '{
        '{id: 16'h0001, pwd: 16'h1111},
        '{id: 16'h0002, pwd: 16'h2222},
        '{id: 16'h0123, pwd: 16'h4567},
        '{id: 16'h9999, pwd: 16'h0000}
    };

    // Key codes 0..9 are BCD digits
    function automatic logic is_digit(input logic [3:0] key);
        return (key <= 4'd9);
    endfunction

    // True when (id, pwd) matches one of the first num_users table entries
    function automatic logic cred_match(input logic [15:0] id,
                                        input logic [15:0] pwd,
                                        input int          num_users);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < CRED_ENTRIES; i++) begin
            if ((i < num_users) && (CRED_TABLE[i].id == id) && (CRED_TABLE[i].pwd == pwd)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/management_bcd_entry_buffer.sv
// Purpose: 4-digit BCD shift-in entry buffer with digit count; digits past the 4th are dropped.
// Latency: 1 clock from clr/shift to updated buffer and count.
// Backpressure: none; clear wins over shift, a full buffer silently ignores shifts.
module bcd_entry_buffer
    import management_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        clr,
    input  logic        shift,
    input  logic [3:0]  digit,
    output logic [15:0] entry_dat,
    output logic [2:0]  entry_cnt
);

    logic [15:0] dat_q, dat_d;
    logic [2:0]  cnt_q, cnt_d;

    // Next buffer value: clear has priority, otherwise shift a digit in from the right
    always_comb begin
        dat_d = dat_q;
        cnt_d = cnt_q;
        if (clr) begin
            dat_d = '0;
            cnt_d = '0;
        end else if (shift && (cnt_q < ENTRY_DIGITS)) begin
            dat_d = {dat_q[11:0], digit};
            cnt_d = cnt_q + 3'd1;
        end
    end

    // Buffer and count registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            dat_q <= '0;
            cnt_q <= '0;
        end else begin
            dat_q <= dat_d;
            cnt_q <= cnt_d;
        end
    end

    assign entry_dat = dat_q;
    assign entry_cnt = cnt_q;

endmodule

// File: rtl/management.sv
// Purpose: keypad login controller; LOGIN, ID, ENTER, password, ENTER against a fixed table.
// Latency: logged_in rises on the edge sampling the matching ENTER, falls on LOGOUT/RST edge.
// Backpressure: none; every sampled key code is one event, unusable keys are dropped.
module management
    import management_pkg::*;
#(
    parameter int NUM_USERS   = 4,
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] BCD_input,
    output logic       logged_in
);

    localparam int FAIL_W = (MAX_FAILS   < 1) ? 1 : $clog2(MAX_FAILS + 1);
    localparam int LOCK_W = (LOCK_CYCLES < 1) ? 1 : $clog2(LOCK_CYCLES + 1);
    localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_FAILS);
    localparam logic [LOCK_W-1:0] LOCK_LOAD  = LOCK_W'(LOCK_CYCLES);

    state_e              state_q, state_d;
    logic [15:0]         id_q, id_d;
    logic [FAIL_W-1:0]   fail_q, fail_d, fail_inc;
    logic [LOCK_W-1:0]   lock_q, lock_d;
    logic                logged_in_q, logged_in_d;

    logic                buf_clr, buf_shift;
    logic [15:0]         entry_dat;
    logic [2:0]          entry_cnt;
    logic                key_digit, key_enter_ok, cred_ok;

    bcd_entry_buffer u_entry (
        .CLK       (CLK),
        .RST       (RST),
        .clr       (buf_clr),
        .shift     (buf_shift),
        .digit     (BCD_input),
        .entry_dat (entry_dat),
        .entry_cnt (entry_cnt)
    );

    assign key_digit    = is_digit(BCD_input);
    // ENTER on an empty buffer is treated as no key
    assign key_enter_ok = (BCD_input == KEY_ENTER) && (entry_cnt != 3'd0);
    // Compare straight off the registered ID latch and buffer, no extra stage
    assign cred_ok      = cred_match(id_q, entry_dat, NUM_USERS);
    assign fail_inc     = fail_q + FAIL_W'(1);

    // Next-state, buffer control, ID latch, fail counter and lock timer
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        fail_d    = fail_q;
        lock_d    = lock_q;
        buf_clr   = 1'b0;
        buf_shift = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (BCD_input == KEY_LOGIN) begin
                    buf_clr = 1'b1;
                    state_d = ST_GET_ID;
                end
            end

            ST_GET_ID: begin
                buf_shift = key_digit;
                if (BCD_input == KEY_CLEAR) begin
                    buf_clr = 1'b1;
                end else if (BCD_input == KEY_LOGOUT) begin
                    state_d = ST_IDLE;
                end else if (key_enter_ok) begin
                    id_d    = entry_dat;
                    buf_clr = 1'b1;
                    state_d = ST_GET_PWD;
                end
            end

            ST_GET_PWD: begin
                buf_shift = key_digit;
                if (BCD_input == KEY_CLEAR) begin
                    buf_clr = 1'b1;
                end else if (BCD_input == KEY_LOGOUT) begin
                    state_d = ST_IDLE;
                end else if (key_enter_ok) begin
                    // Do not leave the typed password sitting in the buffer
                    buf_clr = 1'b1;
                    if (cred_ok) begin
                        fail_d  = '0;
                        state_d = ST_LOGGED_IN;
                    end else if (fail_inc >= FAIL_LIMIT) begin
                        fail_d  = fail_inc;
                        lock_d  = LOCK_LOAD;
                        state_d = ST_LOCKED;
                    end else begin
                        fail_d  = fail_inc;
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_LOGGED_IN: begin
                if (BCD_input == KEY_LOGOUT) begin
                    state_d = ST_IDLE;
                end
            end

            ST_LOCKED: begin
                // Timer was loaded on entry; the edge that takes it 1->0 is the exit edge
                if (lock_q <= LOCK_W'(1)) begin
                    lock_d  = '0;
                    fail_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    lock_d = lock_q - LOCK_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        logged_in_d = (state_d == ST_LOGGED_IN);
    end

    // State, ID latch, counters and registered session flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            id_q        <= '0;
            fail_q      <= '0;
            lock_q      <= '0;
            logged_in_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            fail_q      <= fail_d;
            lock_q      <= lock_d;
            logged_in_q <= logged_in_d;
        end
    end

    assign logged_in = logged_in_q;

endmodule

// File: tb/tb_management.sv
// Purpose: directed table-driven bench for the keypad login controller.
// Latency: each key is driven at negedge and checked 1 time unit after the sampling edge.
// Backpressure: n/a.
module tb_management;
    import management_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] BCD_input = 4'hF;
    logic       logged_in;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [3:0] key;
        logic       exp_li;
        state_e     exp_st;
    } vec_t;

    vec_t vq[$];

    management #(
        .NUM_USERS   (4),
        .MAX_FAILS   (3),
        .LOCK_CYCLES (16)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .BCD_input (BCD_input),
        .logged_in (logged_in)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic press(input logic [3:0] key);
        @(negedge CLK);
        BCD_input = key;
        @(posedge CLK);
        #1;
    endtask

    task automatic enter_digits(input logic [15:0] v);
        press(v[15:12]);
        press(v[11:8]);
        press(v[7:4]);
        press(v[3:0]);
    endtask

    task automatic attempt(input logic [15:0] id, input logic [15:0] pwd);
        press(KEY_LOGIN);
        enter_digits(id);
        press(KEY_ENTER);
        enter_digits(pwd);
        press(KEY_ENTER);
    endtask

    task automatic add(input logic [3:0] key, input logic li, input state_e st);
        vec_t v;
        v.key = key; v.exp_li = li; v.exp_st = st;
        vq.push_back(v);
    endtask

    initial begin
        // Login as 0001/1111 with a stray ENTER on the empty password buffer, ENTER held
        add(4'h0, 0, ST_IDLE);   add(4'h0, 0, ST_IDLE);
        add(4'hB, 0, ST_GET_ID);
        add(4'h0, 0, ST_GET_ID); add(4'h0, 0, ST_GET_ID); add(4'h1, 0, ST_GET_ID);
        add(4'hD, 0, ST_GET_PWD); add(4'hD, 0, ST_GET_PWD);
        add(4'h1, 0, ST_GET_PWD); add(4'h1, 0, ST_GET_PWD);
        add(4'h1, 0, ST_GET_PWD); add(4'h1, 0, ST_GET_PWD);
        add(4'hD, 1, ST_LOGGED_IN); add(4'hD, 1, ST_LOGGED_IN); add(4'hD, 1, ST_LOGGED_IN);
        // Logout, then ENTER must not re-login
        add(4'hC, 0, ST_IDLE); add(4'hD, 0, ST_IDLE);
        // ENTER on empty ID ignored, LOGOUT aborts the dialogue
        add(4'hB, 0, ST_GET_ID); add(4'hD, 0, ST_GET_ID); add(4'hC, 0, ST_IDLE);
        // Reserved key and digits ignored in IDLE
        add(4'hE, 0, ST_IDLE); add(4'h5, 0, ST_IDLE);
        // Unknown ID 0777 fails back to IDLE
        add(4'hB, 0, ST_GET_ID);
        add(4'h0, 0, ST_GET_ID); add(4'h7, 0, ST_GET_ID); add(4'h7, 0, ST_GET_ID); add(4'h7, 0, ST_GET_ID);
        add(4'hD, 0, ST_GET_PWD);
        add(4'h1, 0, ST_GET_PWD); add(4'h2, 0, ST_GET_PWD); add(4'h3, 0, ST_GET_PWD); add(4'h4, 0, ST_GET_PWD);
        add(4'hD, 0, ST_IDLE);

        // Reset
        repeat (2) @(posedge CLK);
        #1;
        check("reset logged_in", 32'(logged_in), 32'd0);
        check("reset state", 32'(dut.state_q), 32'(ST_IDLE));
        check("reset buf", 32'(dut.u_entry.dat_q), 32'h0);
        check("reset cnt", 32'(dut.u_entry.cnt_q), 32'd0);
        check("reset id", 32'(dut.id_q), 32'h0);
        check("reset fail", 32'(dut.fail_q), 32'd0);
        check("reset lock", 32'(dut.lock_q), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Table-driven sequences
        for (int i = 0; i < vq.size(); i++) begin
            press(vq[i].key);
            check($sformatf("vec%0d logged_in", i), 32'(logged_in), 32'(vq[i].exp_li));
            check($sformatf("vec%0d state", i), 32'(dut.state_q), 32'(vq[i].exp_st));
        end
        check("unknown id fail count", 32'(dut.fail_q), 32'd1);

        // Fifth digit dropped, CLEAR empties buffer, then login as 0002/2222
        press(KEY_LOGIN);
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
        check("buf after 5 digits", 32'(dut.u_entry.dat_q), 32'h1234);
        check("cnt after 5 digits", 32'(dut.u_entry.cnt_q), 32'd4);
        press(KEY_CLEAR);
        check("buf after clear", 32'(dut.u_entry.dat_q), 32'h0);
        check("cnt after clear", 32'(dut.u_entry.cnt_q), 32'd0);
        check("state after clear", 32'(dut.state_q), 32'(ST_GET_ID));
        press(4'h2);
        check("buf left padded", 32'(dut.u_entry.dat_q), 32'h0002);
        press(KEY_ENTER);
        check("latched id", 32'(dut.id_q), 32'h0002);
        enter_digits(16'h2222);
        press(KEY_ENTER);
        check("user2 logged_in", 32'(logged_in), 32'd1);
        check("user2 fail cleared", 32'(dut.fail_q), 32'd0);
        press(KEY_LOGOUT);
        check("user2 logout", 32'(logged_in), 32'd0);

        // Three wrong passwords lock the block for exactly 16 clocks
        attempt(16'h0123, 16'h4568);
        check("fail1 state", 32'(dut.state_q), 32'(ST_IDLE));
        check("fail1 count", 32'(dut.fail_q), 32'd1);
        attempt(16'h0123, 16'h4568);
        check("fail2 state", 32'(dut.state_q), 32'(ST_IDLE));
        check("fail2 count", 32'(dut.fail_q), 32'd2);
        attempt(16'h0123, 16'h4568);
        check("fail3 state", 32'(dut.state_q), 32'(ST_LOCKED));
        check("fail3 logged_in", 32'(logged_in), 32'd0);
        for (int k = 1; k <= 16; k++) begin
            press(KEY_LOGIN);
            if (k < 16) begin
                check($sformatf("lock k=%0d state", k), 32'(dut.state_q), 32'(ST_LOCKED));
            end else begin
                check("lock exit state", 32'(dut.state_q), 32'(ST_IDLE));
                check("lock exit fail", 32'(dut.fail_q), 32'd0);
            end
        end
        attempt(16'h0123, 16'h4567);
        check("post-lock login", 32'(logged_in), 32'd1);

        // Reset coincident with ENTER while logged in
        @(negedge CLK);
        RST = 1'b1;
        BCD_input = KEY_ENTER;
        @(posedge CLK);
        #1;
        check("rst logged_in", 32'(logged_in), 32'd0);
        check("rst state", 32'(dut.state_q), 32'(ST_IDLE));
        @(negedge CLK);
        RST = 1'b0;
        press(KEY_ENTER);
        check("post-rst enter", 32'(logged_in), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
